// File: rtl/qnigma_math_chacha_pkg.sv
// ChaCha permutation shared types, index tables and rotate helper.
// Feed-forward add is enabled by defining QNIGMA_CHACHA_FEEDFWD_EN.
package qnigma_math_chacha_pkg;

  typedef logic [15:0][31:0] chacha_state_t;

  typedef enum logic [2:0] {
    QR_A0,
    QR_D0,
    QR_C0,
    QR_B0,
    QR_A1,
    QR_D1,
    QR_C1,
    QR_B1
  } qr_step_t;

  // Slot encoding of the written word within a quarter round
  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  // [qr][slot] -> state word index
  typedef logic [3:0][3:0][3:0] idx_tab_t;

  localparam idx_tab_t COL_IDX =
    64'hFB73_EA62_D951_C840;
  localparam idx_tab_t DIAG_IDX =
    64'hE943_D872_CB61_FA50;

  localparam logic [4:0] ROT_16 = 5'd16;
  localparam logic [4:0] ROT_12 = 5'd12;
  localparam logic [4:0] ROT_8  = 5'd8;
  localparam logic [4:0] ROT_7  = 5'd7;

  // "expand 32-byte k"
  localparam logic [3:0][31:0] SIGMA = {
    32'h6b206574,
    32'h79622d32,
    32'h3320646e,
    32'h61707865
  };

  function automatic logic [31:0] rotl(
    input logic [31:0] x,
    input logic [4:0]  n
  );
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/qnigma_math_chacha_if.sv
// Start/result handshake bundle for the ChaCha permutation core.
// Feed-forward option: QNIGMA_CHACHA_FEEDFWD_EN (core only).
interface qnigma_math_chacha_if;
  import qnigma_math_chacha_pkg::*;

  logic          start;
  chacha_state_t state_i;
  logic          busy;
  logic          done;
  chacha_state_t state_o;

  modport master (
    output start,
    output state_i,
    input  busy,
    input  done,
    input  state_o
  );

  modport slave (
    input  start,
    input  state_i,
    output busy,
    output done,
    output state_o
  );

endinterface

// File: rtl/qnigma_math_chacha_qr_step.sv
// One ChaCha quarter-round step: picks the word to write and its slot.
// Purely combinational; used once per lane.
module qnigma_math_chacha_qr_step
  import qnigma_math_chacha_pkg::*;
(
  input  qr_step_t    step,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] word,
  output logic [1:0]  slot
);

  always_comb begin
    word = a + b;
    slot = SLOT_A;
    case (step)
      QR_A0, QR_A1: begin
        word = a + b;
        slot = SLOT_A;
      end
      QR_D0: begin
        word = rotl(d ^ a, ROT_16);
        slot = SLOT_D;
      end
      QR_C0, QR_C1: begin
        word = c + d;
        slot = SLOT_C;
      end
      QR_B0: begin
        word = rotl(b ^ c, ROT_12);
        slot = SLOT_B;
      end
      QR_D1: begin
        word = rotl(d ^ a, ROT_8);
        slot = SLOT_D;
      end
      QR_B1: begin
        word = rotl(b ^ c, ROT_7);
        slot = SLOT_B;
      end
      default: begin
        word = a + b;
        slot = SLOT_A;
      end
    endcase
  end

endmodule

// File: rtl/qnigma_math_chacha_core.sv
// ChaCha block permutation: ROUNDS rounds over LANES parallel QR lanes.
// QNIGMA_CHACHA_FEEDFWD_EN adds the input state back in the FF cycle.
module qnigma_math_chacha_core
  import qnigma_math_chacha_pkg::*;
#(
  parameter int ROUNDS = 20,
  parameter int LANES  = 1
) (
  input logic                 clk,
  input logic                 rst,
  qnigma_math_chacha_if.slave bus
);

  localparam int PASSES = 4 / LANES;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int DBLS = ROUNDS / 2;
  localparam int DW = (DBLS > 1) ? $clog2(DBLS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FF
  } fsm_t;

  fsm_t          st_q;
  fsm_t          st_d;
  chacha_state_t work_q;
  chacha_state_t out_q;
`ifdef QNIGMA_CHACHA_FEEDFWD_EN
  chacha_state_t in_q;
`endif
  logic          busy_q;
  logic          done_q;
  logic [2:0]    step_q;
  logic [PW-1:0] pass_q;
  logic          half_q;
  logic [DW-1:0] dbl_q;
  logic          pass_last;
  logic          last_step;

  logic [31:0]   lane_word [LANES];
  logic [3:0]    lane_tgt  [LANES];

  assign pass_last = pass_q == PW'(PASSES - 1);
  assign last_step = (step_q == 3'd7) && pass_last
                  && half_q && (dbl_q == DW'(DBLS - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [1:0]       q;
    logic [3:0][3:0]  idx;
    logic [1:0]       slot;

    assign q = 2'(32'(pass_q) * LANES + l);
    assign idx = half_q ? DIAG_IDX[q] : COL_IDX[q];

    qnigma_math_chacha_qr_step u_step (
      .step (qr_step_t'(step_q)),
      .a    (work_q[idx[0]]),
      .b    (work_q[idx[1]]),
      .c    (work_q[idx[2]]),
      .d    (work_q[idx[3]]),
      .word (lane_word[l]),
      .slot (slot)
    );

    assign lane_tgt[l] = idx[slot];
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:  if (bus.start) st_d = S_ROUND;
      S_ROUND: if (last_step) st_d = S_FF;
      S_FF:    st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_IDLE;
      work_q <= '0;
      out_q  <= '0;
`ifdef QNIGMA_CHACHA_FEEDFWD_EN
      in_q   <= '0;
`endif
      busy_q <= 1'b0;
      done_q <= 1'b0;
      step_q <= '0;
      pass_q <= '0;
      half_q <= 1'b0;
      dbl_q  <= '0;
    end else begin
      st_q   <= st_d;
      done_q <= 1'b0;
      case (st_q)
        S_IDLE: begin
          if (bus.start) begin
            work_q <= bus.state_i;
`ifdef QNIGMA_CHACHA_FEEDFWD_EN
            in_q   <= bus.state_i;
`endif
            busy_q <= 1'b1;
            step_q <= '0;
            pass_q <= '0;
            half_q <= 1'b0;
            dbl_q  <= '0;
          end
        end
        S_ROUND: begin
          // lanes of one pass always target disjoint words
          for (int i = 0; i < LANES; i++)
            work_q[lane_tgt[i]] <= lane_word[i];
          step_q <= step_q + 3'd1;
          if (step_q == 3'd7) begin
            if (pass_last) begin
              pass_q <= '0;
              half_q <= ~half_q;
              if (half_q) dbl_q <= dbl_q + 1'b1;
            end else begin
              pass_q <= pass_q + 1'b1;
            end
          end
        end
        S_FF: begin
`ifdef QNIGMA_CHACHA_FEEDFWD_EN
          for (int w = 0; w < 16; w++)
            out_q[w] <= work_q[w] + in_q[w];
`else
          out_q <= work_q;
`endif
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.state_o = out_q;

endmodule

// File: tb/tb_qnigma_math_chacha_core.sv
// Scoreboard bench for qnigma_math_chacha_core on the RFC 8439 block vector.
// Expectations follow QNIGMA_CHACHA_FEEDFWD_EN (raw permutation when undefined).
module tb_qnigma_math_chacha_core;
  import qnigma_math_chacha_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qnigma_math_chacha_if b1 ();
  qnigma_math_chacha_if b2 ();
  qnigma_math_chacha_if b4 ();

  qnigma_math_chacha_core #(.ROUNDS(20), .LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  qnigma_math_chacha_core #(.ROUNDS(20), .LANES(2)) u_l2 (
    .clk(clk), .rst(rst), .bus(b2)
  );
  qnigma_math_chacha_core #(.ROUNDS(20), .LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .bus(b4)
  );

  int total = 0;
  int bad   = 0;

  chacha_state_t vec;
  chacha_state_t exp_st;
  int            lat_tab [3] = '{641, 321, 161};
  time           qa [3][$];

  // Monitor: every done pops one expected accept time
  always @(negedge clk) begin
    logic          dn [3];
    chacha_state_t so [3];
    time           t;
    int            lat;
    dn[0] = b1.done; so[0] = b1.state_o;
    dn[1] = b2.done; so[1] = b2.state_o;
    dn[2] = b4.done; so[2] = b4.state_o;
    for (int i = 0; i < 3; i++) begin
      if (dn[i]) begin
        if (qa[i].size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected dut=%0d got=1 want=0", i);
        end else begin
          t = qa[i].pop_front();
          lat = int'(($time - 5 - t) / 10);
          total++;
          if (lat != lat_tab[i]) begin
            bad++;
            $display("FAIL latency dut=%0d got=%0d want=%0d",
                     i, lat, lat_tab[i]);
          end
          total++;
          if (so[i] !== exp_st) begin
            bad++;
            $display("FAIL state dut=%0d got=%h want=%h",
                     i, so[i], exp_st);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [511:0] got,
                     input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic go(input bit d1, input bit d2, input bit d4);
    @(negedge clk);
    b1.start = d1; b2.start = d2; b4.start = d4;
    @(posedge clk);
    if (d1) qa[0].push_back($time);
    if (d2) qa[1].push_back($time);
    if (d4) qa[2].push_back($time);
    @(negedge clk);
    b1.start = 1'b0; b2.start = 1'b0; b4.start = 1'b0;
  endtask

  task automatic wait_empty(input int lim);
    int n = 0;
    while ((qa[0].size() + qa[1].size() + qa[2].size()) != 0
           && n < lim) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= lim) begin
      bad++;
      $display("FAIL timeout got=%0d want<%0d cycles", n, lim);
    end
  endtask

  initial begin
    vec[3:0]   = SIGMA;
    vec[4]     = 32'h03020100; vec[5]  = 32'h07060504;
    vec[6]     = 32'h0b0a0908; vec[7]  = 32'h0f0e0d0c;
    vec[8]     = 32'h13121110; vec[9]  = 32'h17161514;
    vec[10]    = 32'h1b1a1918; vec[11] = 32'h1f1e1d1c;
    vec[12]    = 32'h00000001; vec[13] = 32'h09000000;
    vec[14]    = 32'h4a000000; vec[15] = 32'h00000000;
`ifdef QNIGMA_CHACHA_FEEDFWD_EN
    exp_st = {32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
              32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
              32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
              32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};
`else
    exp_st = {32'h4e3c50a2, 32'h9e83d0cb, 32'hb04e16de, 32'hd19c12b4,
              32'h82e46ebd, 32'heabda8fc, 32'hf29489f3, 32'h335271c2,
              32'h3f5ec7b7, 32'h8fa018fc, 32'hfc62bb2f, 32'hc4f2d0c7,
              32'h5950bb2f, 32'ha67ae21e, 32'he238d763, 32'h837778ab};
`endif
    b1.start = 1'b0; b2.start = 1'b0; b4.start = 1'b0;
    b1.state_i = vec; b2.state_i = vec; b4.state_i = vec;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 512'(b1.busy), 512'(0));
    chk("rst_done", 512'(b1.done), 512'(0));
    chk("rst_state", b1.state_o, '0);

    // all three widths, extra starts on L1 while busy
    go(1'b1, 1'b1, 1'b1);
    b1.state_i = ~vec;
    repeat (3) @(negedge clk);
    b1.start = 1'b1;
    chk("busy_c5", 512'(b1.busy), 512'(1));
    @(negedge clk);
    b1.start = 1'b0;
    repeat (94) @(negedge clk);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    b1.state_i = vec;
    wait_empty(800);
    repeat (700) @(negedge clk);

    // abort at cycle 200
    go(1'b1, 1'b0, 1'b0);
    repeat (198) @(negedge clk);
    rst = 1'b1;
    qa[0].delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 512'(b1.busy), 512'(0));
    chk("abort_state", b1.state_o, '0);
    repeat (700) @(negedge clk);
    chk("abort_state_late", b1.state_o, '0);

    go(1'b1, 1'b0, 1'b0);
    wait_empty(800);

    // start held high through done
    @(negedge clk);
    b1.start = 1'b1;
    @(posedge clk);
    qa[0].push_back($time);
    qa[0].push_back($time + 6420);
    repeat (642) @(posedge clk);
    @(negedge clk);
    b1.start = 1'b0;
    chk("b2b_busy", 512'(b1.busy), 512'(1));
    wait_empty(1500);
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
